ex_redirect_ctrl: RTL and testbench

//  Sequences the pipeline response to exceptions and ERET committed in WB.

---
 rtl/ex_redirect_ctrl_pkg.sv | 14 +
 rtl/ex_redirect_ctrl_if.sv | 26 ++
 rtl/ex_redirect_ctrl_outs_counter.sv | 35 +++
 rtl/ex_redirect_ctrl.sv | 60 ++++++
 tb/tb_ex_redirect_ctrl.sv | 114 +++++++++++
 5 files changed

// File: rtl/ex_redirect_ctrl_pkg.sv
// ex_redirect_ctrl_pkg: shared CP0 field positions, redirect constants and FSM encoding
package ex_redirect_ctrl_pkg;
  localparam logic [31:0] EX_ENTRY = 32'hbfc00380;
  localparam int MAX_OUTS = 2;
  localparam int CNT_W = 2;
  localparam int ST_IE = 0;
  localparam int ST_EXL = 1;
  localparam int IM_LO = 8;
  localparam int IM_HI = 15;
  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, REDIR = 2'd2} state_t;
  function automatic logic int_pending(input logic [31:0] status, input logic [31:0] cause);
    return status[ST_IE] & ~status[ST_EXL] & |(status[IM_HI:IM_LO] & cause[IM_HI:IM_LO]);
  endfunction
endpackage

// File: rtl/ex_redirect_ctrl_if.sv
// ex_redirect_ctrl_if: WB event, CP0, inst-SRAM handshake and IF redirect signals
interface ex_redirect_ctrl_if;
  logic        ws_ex;
  logic        ws_eret;
  logic [31:0] cp0_epc;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic        inst_req_fire;
  logic        inst_resp_fire;
  logic        redirect_ready;
  logic        pipe_flush;
  logic        fetch_block;
  logic        discard_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        has_int;
  logic        outs_ovf;
  modport master (
    output ws_ex, ws_eret, cp0_epc, cp0_status, cp0_cause, inst_req_fire, inst_resp_fire, redirect_ready,
    input  pipe_flush, fetch_block, discard_resp, redirect_valid, redirect_pc, has_int, outs_ovf
  );
  modport slave (
    input  ws_ex, ws_eret, cp0_epc, cp0_status, cp0_cause, inst_req_fire, inst_resp_fire, redirect_ready,
    output pipe_flush, fetch_block, discard_resp, redirect_valid, redirect_pc, has_int, outs_ovf
  );
endinterface

// File: rtl/ex_redirect_ctrl_outs_counter.sv
// ex_redirect_ctrl_outs_counter: saturating outstanding-fetch counter with sticky overflow
module ex_redirect_ctrl_outs_counter
  import ex_redirect_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_cnt_next,
  output logic             o_ovf
);
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_full;
  logic             w_empty;
  assign w_full  = r_cnt == CNT_W'(MAX_OUTS);
  assign w_empty = r_cnt == '0;
  always_comb begin
    o_cnt_next = r_cnt;
    if (i_inc && !i_dec && !w_full) o_cnt_next = r_cnt + 1'b1;
    else if (i_dec && !i_inc && !w_empty) o_cnt_next = r_cnt - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= o_cnt_next;
      r_ovf <= r_ovf | (i_inc & ~i_dec & w_full);
    end
  end
  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;
endmodule

// File: rtl/ex_redirect_ctrl.sv
// ex_redirect_ctrl: flush, drain outstanding fetches, then redirect IF on exception/ERET
module ex_redirect_ctrl
  import ex_redirect_ctrl_pkg::*;
(
  input logic            clk,
  input logic            reset,
  ex_redirect_ctrl_if.slave bus
);
  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_target;
  logic             r_has_int;
  logic             w_event;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  ex_redirect_ctrl_outs_counter u_outs (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (bus.inst_req_fire),
    .i_dec     (bus.inst_resp_fire),
    .o_cnt     (w_cnt),
    .o_cnt_next(w_cnt_next),
    .o_ovf     (bus.outs_ovf)
  );
  assign w_event = bus.ws_ex | bus.ws_eret;
  always_comb begin
    w_state_next       = r_state;
    bus.pipe_flush     = 1'b1;
    bus.fetch_block    = 1'b1;
    bus.discard_resp   = bus.inst_resp_fire;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    if (r_state == IDLE) begin
      bus.pipe_flush   = w_event;
      bus.fetch_block  = 1'b0;
      bus.discard_resp = 1'b0;
      if (w_event) w_state_next = (w_cnt_next != '0) ? DRAIN : REDIR;
    end else if (r_state == DRAIN) begin
      if (w_cnt_next == '0) w_state_next = REDIR;
    end else begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = r_target;
      if (bus.redirect_ready) w_state_next = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_target  <= 32'h0;
      r_has_int <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_has_int <= (r_state == IDLE) & int_pending(bus.cp0_status, bus.cp0_cause);
      if (r_state == IDLE && w_event) r_target <= bus.ws_ex ? EX_ENTRY : bus.cp0_epc;
    end
  end
  assign bus.has_int = r_has_int;
  logic w_unused;
  assign w_unused = ^w_cnt;
endmodule

// File: tb/tb_ex_redirect_ctrl.sv
// tb_ex_redirect_ctrl: directed vectors with hand-computed expectations for ex_redirect_ctrl
module tb_ex_redirect_ctrl;
  logic clk = 1'b0;
  logic reset;
  int tests = 0;
  int fails = 0;
  ex_redirect_ctrl_if bus ();
  ex_redirect_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_flush"}, 32'(bus.pipe_flush), 0);
    check({tag, "_block"}, 32'(bus.fetch_block), 0);
    check({tag, "_disc"}, 32'(bus.discard_resp), 0);
    check({tag, "_rv"}, 32'(bus.redirect_valid), 0);
    check({tag, "_pc"}, bus.redirect_pc, 0);
  endtask
  always @(negedge clk)
    if (!reset) assert (!(bus.fetch_block && (bus.ws_ex || bus.ws_eret)));
  initial begin
    reset = 1'b1;
    bus.ws_ex = 0; bus.ws_eret = 0; bus.cp0_epc = 0; bus.cp0_status = 0; bus.cp0_cause = 0;
    bus.inst_req_fire = 0; bus.inst_resp_fire = 0; bus.redirect_ready = 0;
    step(); step();
    check_idle("rst");
    check("rst_int", 32'(bus.has_int), 0);
    check("rst_ovf", 32'(bus.outs_ovf), 0);
    reset = 1'b0;
    step();
    // exception with nothing outstanding: redirect one cycle later
    bus.ws_ex = 1; bus.cp0_epc = 32'h1234; #1;
    check("t1_flush", 32'(bus.pipe_flush), 1);
    check("t1_rv0", 32'(bus.redirect_valid), 0);
    step(); bus.ws_ex = 0; #1;
    check("t1_rv", 32'(bus.redirect_valid), 1);
    check("t1_pc", bus.redirect_pc, 32'hbfc00380);
    check("t1_block", 32'(bus.fetch_block), 1);
    bus.redirect_ready = 1; step(); bus.redirect_ready = 0; #1;
    check_idle("t1_idle");
    // ERET with two fetches outstanding: drain then redirect to EPC
    bus.inst_req_fire = 1; step(); step(); bus.inst_req_fire = 0;
    bus.ws_eret = 1; bus.cp0_epc = 32'hbfc00100; #1;
    check("t2_flush", 32'(bus.pipe_flush), 1);
    step(); bus.ws_eret = 0; #1;
    check("t2_drain_rv", 32'(bus.redirect_valid), 0);
    check("t2_drain_block", 32'(bus.fetch_block), 1);
    bus.inst_resp_fire = 1; #1;
    check("t2_disc1", 32'(bus.discard_resp), 1);
    step();
    check("t2_disc2", 32'(bus.discard_resp), 1);
    check("t2_rv_mid", 32'(bus.redirect_valid), 0);
    step(); bus.inst_resp_fire = 0; #1;
    check("t2_rv", 32'(bus.redirect_valid), 1);
    check("t2_pc", bus.redirect_pc, 32'hbfc00100);
    // ready held low: redirect stays stable
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_rv", 32'(bus.redirect_valid), 1);
      check("t4_pc", bus.redirect_pc, 32'hbfc00100);
      check("t4_block", 32'(bus.fetch_block), 1);
    end
    bus.redirect_ready = 1; step(); bus.redirect_ready = 0; #1;
    check_idle("t4_idle");
    // simultaneous exception and ERET: exception entry wins
    bus.ws_ex = 1; bus.ws_eret = 1; bus.cp0_epc = 32'h80000000;
    step(); bus.ws_ex = 0; bus.ws_eret = 0; #1;
    check("t3_pc", bus.redirect_pc, 32'hbfc00380);
    bus.redirect_ready = 1; step(); bus.redirect_ready = 0; #1;
    // interrupt pending flag
    bus.cp0_status = 32'h0000ff01; bus.cp0_cause = 32'h00000400; #1;
    check("t5_int_pre", 32'(bus.has_int), 0);
    step();
    check("t5_int", 32'(bus.has_int), 1);
    bus.cp0_status = 32'h0000ff03; step();
    check("t5_exl", 32'(bus.has_int), 0);
    bus.cp0_status = 32'h0000ff01; step();
    check("t5_int2", 32'(bus.has_int), 1);
    bus.inst_req_fire = 1; step(); bus.inst_req_fire = 0;
    bus.ws_ex = 1; step(); bus.ws_ex = 0; #1;
    check("t5_drain_block", 32'(bus.fetch_block), 1);
    step();
    check("t5_drain_int", 32'(bus.has_int), 0);
    check("t5_drain_rv", 32'(bus.redirect_valid), 0);
    // reset mid-drain with one fetch outstanding
    reset = 1; step(); reset = 0; #1;
    check_idle("t6_rst");
    check("t6_int", 32'(bus.has_int), 0);
    check("t6_ovf", 32'(bus.outs_ovf), 0);
    bus.cp0_status = 0;
    bus.inst_resp_fire = 1; step(); bus.inst_resp_fire = 0;
    bus.ws_ex = 1; step(); bus.ws_ex = 0; #1;
    check("t6_cnt0_rv", 32'(bus.redirect_valid), 1);
    bus.redirect_ready = 1; step(); bus.redirect_ready = 0; #1;
    // overflow: three request fires against a limit of two
    bus.inst_req_fire = 1; step(); step();
    check("t6_ovf_pre", 32'(bus.outs_ovf), 0);
    step(); bus.inst_req_fire = 0; #1;
    check("t6_ovf", 32'(bus.outs_ovf), 1);
    step();
    check("t6_ovf_sticky", 32'(bus.outs_ovf), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
